// File: rtl/multimode_counter.sv
// Run-controlled up/down counter: wrap or one-shot, pause/resume, preload, prescaled steps.
// Latency: running rises 1 edge after start, first step PRESCALE edges later; no backpressure.
module multimode_counter #(
    parameter int WIDTH    = 10,
    parameter int PRESCALE = 1
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic             i_clear,
    input  logic             i_dir,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_limit,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_value,
    output logic [WIDTH-1:0] o_count_out,
    output logic             o_running,
    output logic             o_done,
    output logic             o_tc
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] r_limit, w_limit_nxt;
    logic [PW-1:0]    r_pre,   w_pre_nxt;
    logic             r_flag,  w_flag_nxt;
    logic             r_dir,   w_dir_nxt;
    logic             r_mode,  w_mode_nxt;
    logic             r_tc,    w_tc_nxt;

    logic             w_tick;
    logic [WIDTH-1:0] w_inc;
    logic [WIDTH-1:0] w_dec;

    assign w_tick = (r_pre == PRE_MAX);
    assign w_inc  = r_count + 1'b1;
    assign w_dec  = r_count - 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_limit <= '0;
            r_pre   <= '0;
            r_flag  <= 1'b0;
            r_dir   <= 1'b0;
            r_mode  <= 1'b0;
            r_tc    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_limit <= w_limit_nxt;
            r_pre   <= w_pre_nxt;
            r_flag  <= w_flag_nxt;
            r_dir   <= w_dir_nxt;
            r_mode  <= w_mode_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_limit_nxt = r_limit;
        w_pre_nxt   = r_pre;
        w_flag_nxt  = r_flag;
        w_dir_nxt   = r_dir;
        w_mode_nxt  = r_mode;
        w_tc_nxt    = 1'b0;

        if (i_clear) begin
            w_state_nxt = S_IDLE;
            w_count_nxt = '0;
            w_pre_nxt   = '0;
            w_flag_nxt  = 1'b0;
        end else if (i_stop) begin
            if (r_state == S_RUN) begin
                w_state_nxt = S_PAUSE;
            end
        end else if (i_start && (r_state != S_RUN)) begin
            w_state_nxt = S_RUN;
            if (r_state != S_PAUSE) begin
                // Fresh run: take new settings; a pending preload already sits in r_count.
                w_dir_nxt   = i_dir;
                w_mode_nxt  = i_mode;
                w_limit_nxt = i_limit;
                w_pre_nxt   = '0;
                w_flag_nxt  = 1'b0;
                if (!r_flag) begin
                    w_count_nxt = i_dir ? '0 : i_limit;
                end
            end
        end else if (i_load && (r_state != S_RUN)) begin
            w_count_nxt = i_load_value;
            if (r_state != S_PAUSE) begin
                w_flag_nxt = 1'b1;
            end
        end else if (r_state == S_RUN) begin
            if (!w_tick) begin
                w_pre_nxt = r_pre + 1'b1;
            end else begin
                w_pre_nxt = '0;
                if (r_dir) begin
                    if (r_count >= r_limit) begin
                        // One-shot already at (or past) terminal: finish without moving.
                        w_tc_nxt = r_mode | (r_limit == '0);
                        if (r_mode) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_count_nxt = '0;
                        end
                    end else begin
                        w_count_nxt = w_inc;
                        w_tc_nxt    = (w_inc == r_limit);
                        if (r_mode && (w_inc == r_limit)) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end else begin
                    if (r_count == '0) begin
                        w_tc_nxt = r_mode | (r_limit == '0);
                        if (r_mode) begin
                            w_state_nxt = S_DONE;
                        end else begin
                            w_count_nxt = r_limit;
                        end
                    end else begin
                        w_count_nxt = w_dec;
                        w_tc_nxt    = (w_dec == '0);
                        if (r_mode && (w_dec == '0)) begin
                            w_state_nxt = S_DONE;
                        end
                    end
                end
            end
        end
    end

    assign o_count_out = r_count;
    assign o_running   = (r_state == S_RUN);
    assign o_done      = (r_state == S_DONE);
    assign o_tc        = r_tc;

endmodule
